alu_4bit_scan_ctrl: RTL and testbench
=====================================

ALU_4BIT_SCAN_CTRL -- requirements
Module: alu_4bit_scan_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 1, idle cycles between driving a vector and sampling the ALU (0..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  begin a scan, sampled on a clk edge in IDLE or DONE.
REQ-005 SHALL have port: abort  input  1  terminate a scan in progress.
REQ-006 SHALL have port: alu_a  output  4  operand A driven to the ALU under test.
REQ-007 SHALL have port: alu_b  output  4  operand B driven to the ALU under test.
REQ-008 SHALL have port: alu_opcode  output  3  opcode driven to the ALU under test.
REQ-009 SHALL have port: alu_result  input  4  result returned by the ALU under test.
REQ-010 SHALL have port: alu_zero  input  1  zero flag returned by the ALU under test.
REQ-011 SHALL have port: busy  output  1  scan in progress.
REQ-012 SHALL have port: done  output  1  scan completed; held until next start or reset.
REQ-013 SHALL have port: pass  output  1  done with fail_count==0.
REQ-014 SHALL have port: fail_count  output  12  number of mismatching vectors.
REQ-015 SHALL have port: first_fail_vec  output  11  index of first mismatching vector.
REQ-016 SHALL have port: first_fail_result  output  4  alu_result captured at first mismatch.
REQ-017 SHALL have port: first_fail_zero  output  1  alu_zero captured at first mismatch.

Function
REQ-018 SHALL scan 2048 vectors, index v = 0..2047 ascending: opcode=v[10:8], A=v[7:4], B=v[3:0].
REQ-019 SHALL use FSM IDLE, DRIVE, WAIT, CHECK, DONE; alu_a/alu_b/alu_opcode registered, updated only in DRIVE, held through WAIT and CHECK.
REQ-020 SHALL transition: IDLE/DONE + start -> DRIVE (v=0, counters and first_fail_* cleared); DRIVE -> WAIT (SETTLE_CYCLES>0) else CHECK; WAIT stays exactly SETTLE_CYCLES cycles -> CHECK; CHECK -> DRIVE (v+1) or DONE when v==2047.
REQ-021 SHALL compute golden per vector: 000 A+B mod 16; 001 A-B mod 16; 010 A&B; 011 A|B; 100 A^B; 101 (A==B)?1:0; 110 unsigned (A<B)?1:0; 111 0; golden zero = (golden result==0).
REQ-022 SHALL in CHECK count one mismatch per vector if alu_result or alu_zero differs from golden; on first mismatch capture v, alu_result, alu_zero into first_fail_*.
REQ-023 SHALL take SETTLE_CYCLES+2 cycles per vector; done SHALL rise 2048*(SETTLE_CYCLES+2) edges after the edge sampling start.
REQ-024 SHALL keep busy=1 in DRIVE/WAIT/CHECK, done=1 only in DONE, pass=done&(fail_count==0).
REQ-025 SHALL ignore start while busy; abort while busy SHALL return to IDLE next edge with done=0, fail_count and first_fail_* retained; abort in IDLE/DONE ignored; abort wins over start same cycle.
REQ-026 SHALL never overflow fail_count (max 2048 fits 12 bits).

Reset
REQ-027 SHALL on rst, at any time including mid-scan, force IDLE and all outputs to 0 (alu_a, alu_b, alu_opcode, busy, done, pass, fail_count, first_fail_*).

Configuration
REQ-028 SHALL support macro ALU_SCAN_STOP_ON_FAIL_EN: defined -> CHECK with a mismatch goes directly to DONE (fail_count=1, pass=0); undefined -> full 2048-vector scan always.

Verification
REQ-029 Correct ALU, SETTLE_CYCLES=1, start -> done at edge 6144, fail_count=0, pass=1.
REQ-030 ALU with AND->OR, OR->AND, XOR->AND substitutions, macro undefined -> fail_count=735, first_fail_vec=0x201, first_fail_result=4'b0001, first_fail_zero=0, pass=0.
REQ-031 Same mutant ALU, ALU_SCAN_STOP_ON_FAIL_EN defined -> done after vector 0x201 CHECK, fail_count=1, first_fail_vec=0x201.
REQ-032 abort asserted during vector 100 -> busy=0 next edge, done=0; subsequent start restarts at v=0 with fail_count=0.
REQ-033 rst pulsed mid-scan -> all outputs 0 asynchronously; start pulsed while busy -> no effect on scan timing.

Source files
------------

// File: rtl/alu_4bit_scan_ctrl.sv
// Exhaustive 2048-vector self-test of an external 4-bit ALU; SETTLE_CYCLES+2 clocks per vector.
// Optional ALU_SCAN_STOP_ON_FAIL_EN: end the scan at the first mismatching vector.
module alu_4bit_scan_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [2:0]  alu_opcode,
   input  logic [3:0]  alu_result,
   input  logic        alu_zero,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [11:0] fail_count,
   output logic [10:0] first_fail_vec,
   output logic [3:0]  first_fail_result,
   output logic        first_fail_zero
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_DRIVE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [10:0] vec;
   logic [3:0]  wait_cnt;
   logic [3:0]  golden_res;
   logic        golden_zero;
   logic        mismatch;
   logic        last_vec;
   logic        stop_scan;
   logic        start_scan;

   always_comb begin
      golden_res = 4'd0;
      case (alu_opcode)
         3'b000:  golden_res = alu_a + alu_b;
         3'b001:  golden_res = alu_a - alu_b;
         3'b010:  golden_res = alu_a & alu_b;
         3'b011:  golden_res = alu_a | alu_b;
         3'b100:  golden_res = alu_a ^ alu_b;
         3'b101:  golden_res = {3'b000, (alu_a == alu_b)};
         3'b110:  golden_res = {3'b000, (alu_a < alu_b)};
         default: golden_res = 4'd0;
      endcase
   end

   assign golden_zero = (golden_res == 4'd0);
   assign mismatch    = (alu_result != golden_res) || (alu_zero != golden_zero);
   assign last_vec    = (vec == 11'h7FF);

`ifdef ALU_SCAN_STOP_ON_FAIL_EN
   assign stop_scan = last_vec || mismatch;
`else
   assign stop_scan = last_vec;
`endif

   assign busy = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
   assign done = (state == ST_DONE);
   assign pass = done && (fail_count == 12'd0);

   // abort also suppresses a simultaneous start from IDLE/DONE
   assign start_scan = ((state == ST_IDLE) || (state == ST_DONE)) && start && !abort;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start_scan) state_nxt = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (abort)                   state_nxt = ST_IDLE;
            else if (SETTLE_CYCLES == 0) state_nxt = ST_CHECK;
            else                         state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (abort)                 state_nxt = ST_IDLE;
            else if (wait_cnt == 4'd0) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (abort)          state_nxt = ST_IDLE;
            else if (stop_scan) state_nxt = ST_DONE;
            else                state_nxt = ST_DRIVE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         vec               <= 11'd0;
         wait_cnt          <= 4'd0;
         alu_a             <= 4'd0;
         alu_b             <= 4'd0;
         alu_opcode        <= 3'd0;
         fail_count        <= 12'd0;
         first_fail_vec    <= 11'd0;
         first_fail_result <= 4'd0;
         first_fail_zero   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (start_scan) begin
            vec               <= 11'd0;
            fail_count        <= 12'd0;
            first_fail_vec    <= 11'd0;
            first_fail_result <= 4'd0;
            first_fail_zero   <= 1'b0;
         end

         if (state == ST_DRIVE) begin
            alu_opcode <= vec[10:8];
            alu_a      <= vec[7:4];
            alu_b      <= vec[3:0];
            wait_cnt   <= SETTLE_LAST;
         end

         if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if ((state == ST_CHECK) && !abort) begin
            if (mismatch) begin
               fail_count <= fail_count + 12'd1;
               if (fail_count == 12'd0) begin
                  first_fail_vec    <= vec;
                  first_fail_result <= alu_result;
                  first_fail_zero   <= alu_zero;
               end
            end
            if (!stop_scan) vec <= vec + 11'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_4bit_scan_ctrl.sv
// Directed bench for alu_4bit_scan_ctrl: bench-side ALU (correct / mutant / stuck-zero) and a per-cycle scoreboard.
module tb_alu_4bit_scan_ctrl;

   localparam int S = 1;
   localparam int P = S + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [2:0]  alu_opcode;
   logic [3:0]  alu_result;
   logic        alu_zero;
   logic        busy;
   logic        done;
   logic        pass;
   logic [11:0] fail_count;
   logic [10:0] first_fail_vec;
   logic [3:0]  first_fail_result;
   logic        first_fail_zero;

   int mode;
   int n_checks;
   int n_pass;
   int cyc;
   bit tracking;
   int k;

   int pre [0:2048];
   int m_ffv;
   int m_last;
   int m_done_edge;

   always #5 clk = ~clk;

   alu_4bit_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .abort             (abort),
      .alu_a             (alu_a),
      .alu_b             (alu_b),
      .alu_opcode        (alu_opcode),
      .alu_result        (alu_result),
      .alu_zero          (alu_zero),
      .busy              (busy),
      .done              (done),
      .pass              (pass),
      .fail_count        (fail_count),
      .first_fail_vec    (first_fail_vec),
      .first_fail_result (first_fail_result),
      .first_fail_zero   (first_fail_zero)
   );

   function automatic logic [3:0] golden_of(input int v);
      int op, a, b;
      op = (v >> 8) & 7;
      a  = (v >> 4) & 15;
      b  = v & 15;
      case (op)
         0: return 4'((a + b) % 16);
         1: return 4'((a - b + 16) % 16);
         2: return 4'(a & b);
         3: return 4'(a | b);
         4: return 4'(a ^ b);
         5: return (a == b) ? 4'd1 : 4'd0;
         6: return (a < b) ? 4'd1 : 4'd0;
         default: return 4'd0;
      endcase
   endfunction

   // mode 0: good ALU, 1: AND->OR / OR->AND / XOR->AND, 2: zero flag stuck low
   function automatic logic [4:0] alu_of(input int m, input int v);
      logic [3:0] r;
      int op, a, b;
      op = (v >> 8) & 7;
      a  = (v >> 4) & 15;
      b  = v & 15;
      r  = golden_of(v);
      if (m == 1) begin
         if (op == 2)      r = 4'(a | b);
         else if (op == 3) r = 4'(a & b);
         else if (op == 4) r = 4'(a & b);
      end
      if (m == 2) return {1'b0, r};
      return {(r == 4'd0), r};
   endfunction

   always_comb begin
      {alu_zero, alu_result} = alu_of(mode, int'({alu_opcode, alu_a, alu_b}));
   end

   task automatic build_model(input int m);
      logic [3:0] g;
      pre[0] = 0;
      m_ffv  = -1;
      for (int v = 0; v < 2048; v++) begin
         g = golden_of(v);
         if (alu_of(m, v) != {(g == 4'd0), g}) begin
            pre[v+1] = pre[v] + 1;
            if (m_ffv < 0) m_ffv = v;
         end else begin
            pre[v+1] = pre[v];
         end
      end
      m_last = 2047;
`ifdef ALU_SCAN_STOP_ON_FAIL_EN
      if (m_ffv >= 0) m_last = m_ffv;
`endif
      m_done_edge = (m_last + 1) * P;
   endtask

   // expected outputs n edges after the edge that sampled start
   function automatic logic [41:0] exp_pack(input int n);
      int checked, ld, fc;
      logic bz, dn;
      logic [4:0]  r;
      logic [15:0] ff;
      logic [10:0] av;
      bz      = (n < m_done_edge);
      dn      = !bz;
      checked = n / P;
      if (checked > m_last + 1) checked = m_last + 1;
      fc = pre[checked];
      ff = 16'd0;
      if (fc > 0) begin
         r  = alu_of(mode, m_ffv);
         ff = {11'(m_ffv), r[3:0], r[4]};
      end
      av = 11'd0;
      if (n >= 1) begin
         ld = (n - 1) / P;
         if (ld > m_last) ld = m_last;
         av = 11'(ld);
      end
      return {bz, dn, (dn && fc == 0), 12'(fc), ff, av};
   endfunction

   function automatic logic [41:0] out_pack(input bit with_alu);
      logic [10:0] av;
      av = with_alu ? {alu_opcode, alu_a, alu_b} : 11'd0;
      return {busy, done, pass, fail_count, first_fail_vec, first_fail_result, first_fail_zero, av};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (tracking) begin
         chk($sformatf("cycle_%0d", cyc), 64'(out_pack(cyc >= 1)), 64'(exp_pack(cyc)));
         cyc++;
      end
   end

   task automatic start_scan(input int m);
      mode = m;
      build_model(m);
      @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      cyc      = 0;
      tracking = 1'b1;
   endtask

   task automatic wait_done(input int pulse_at, output int kk);
      kk = 0;
      @(negedge clk);
      while (!done && kk < 20000) begin
         start = (kk == pulse_at);
         @(negedge clk);
         kk++;
      end
      start = 1'b0;
      chk("done_reached", 64'(done), 64'd1);
   endtask

   task automatic end_track();
      @(posedge clk);
      #2 tracking = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
      tracking = 1'b0; cyc = 0; n_checks = 0; n_pass = 0; k = 0;
      #3 chk("reset_outputs", 64'(out_pack(1'b1)), 64'd0);
      @(posedge clk);
      #2 rst = 1'b0;

      // good ALU: full scan
      start_scan(0);
      chk("model_good_fails", 64'(pre[m_last+1]), 64'd0);
      wait_done(-1, k);
      chk("good_done_edge", 64'(k), 64'd6144);
      end_track();
      chk("good_pass", 64'(pass), 64'd1);
      chk("good_fail_count", 64'(fail_count), 64'd0);

      // abort while DONE is ignored
      @(posedge clk);
      #2 abort = 1'b1;
      @(posedge clk);
      #2 abort = 1'b0;
      chk("abort_in_done", 64'({busy, done}), 64'd1);

      // mutant ALU
      start_scan(1);
      chk("model_mutant_ffv", 64'(m_ffv), 64'h201);
      wait_done(-1, k);
`ifdef ALU_SCAN_STOP_ON_FAIL_EN
      chk("mutant_done_edge", 64'(k), 64'd1542);
      end_track();
      chk("mutant_fail_count", 64'(fail_count), 64'd1);
`else
      chk("model_mutant_fails", 64'(pre[2048]), 64'd735);
      chk("mutant_done_edge", 64'(k), 64'd6144);
      end_track();
      chk("mutant_fail_count", 64'(fail_count), 64'd735);
`endif
      chk("mutant_first_vec", 64'(first_fail_vec), 64'h201);
      chk("mutant_first_result", 64'(first_fail_result), 64'd1);
      chk("mutant_first_zero", 64'(first_fail_zero), 64'd0);
      chk("mutant_pass", 64'(pass), 64'd0);

      // stuck zero flag, with a start pulse while busy
      start_scan(2);
      wait_done(m_done_edge / 2, k);
`ifdef ALU_SCAN_STOP_ON_FAIL_EN
      chk("stuck_done_edge", 64'(k), 64'd3);
      end_track();
      chk("stuck_fail_count", 64'(fail_count), 64'd1);
`else
      chk("model_stuck_fails", 64'(pre[2048]), 64'd762);
      chk("stuck_done_edge", 64'(k), 64'd6144);
      end_track();
      chk("stuck_fail_count", 64'(fail_count), 64'd762);
`endif
      chk("stuck_first_vec", 64'(first_fail_vec), 64'd0);

      // abort during vector 100
`ifdef ALU_SCAN_STOP_ON_FAIL_EN
      start_scan(0);
`else
      start_scan(2);
`endif
      repeat (301) @(posedge clk);
      #2 abort = 1'b1;
      tracking = 1'b0;
      @(posedge clk);
      #2 abort = 1'b0;
      chk("abort_busy_done", 64'({busy, done}), 64'd0);
`ifdef ALU_SCAN_STOP_ON_FAIL_EN
      chk("abort_fail_count", 64'(fail_count), 64'd0);
`else
      chk("abort_fail_count", 64'(fail_count), 64'd6);
      chk("abort_first_zero_vec", 64'({first_fail_vec, first_fail_result, first_fail_zero}), 64'd0);
`endif
      @(posedge clk);
      #2 chk("abort_stays_idle", 64'({busy, done}), 64'd0);

      // restart from v=0, then asynchronous reset mid-scan
      start_scan(0);
      repeat (400) @(posedge clk);
      #2 tracking = 1'b0;
      chk("restart_vec", 64'({alu_opcode, alu_a, alu_b}), 64'd133);
      chk("restart_fail_count", 64'(fail_count), 64'd0);
      #1 rst = 1'b1;
      #1 chk("rst_async_outputs", 64'(out_pack(1'b1)), 64'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2 chk("post_rst_idle", 64'(out_pack(1'b1)), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
